// File: rtl/proc_pkg.sv
// Shared types for the memory/writeback stage: FSM states, default widths
// and the registered MEM/WB bundle layout.
package proc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] pc;
    logic                  reg_write;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_DATA_W-1:0] wdata;
    logic                  halt;
    logic                  err;
  } memwb_bundle_t;

endpackage

// File: rtl/mem_wb_timeout_ctr.sv
// Saturating WAIT-cycle counter; o_expired rises once TIMEOUT cycles have
// been counted and stays high until cleared.
module mem_wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  // Clear wins over enable so leaving WAIT always starts the next access at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-stage controller and MEM/WB pipeline register.
// Optional macro MEM_WB_STAGE_PERF_EN enables the data-cache request/hit counters.
module mem_wb_stage
  import proc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exmem_valid,
  input  logic [DATA_W-1:0] exmem_pc,
  input  logic              exmem_mem_read,
  input  logic              exmem_mem_write,
  input  logic [DATA_W-1:0] exmem_addr,
  input  logic [DATA_W-1:0] exmem_wdata,
  input  logic [DATA_W-1:0] exmem_alu_out,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_halt,
  output logic              dmem_req,
  output logic              dmem_wr,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_done,
  input  logic              dmem_hit,
  input  logic              dmem_err,
  output logic              mem_busy,
  output logic              memwb_valid,
  output logic [DATA_W-1:0] memwb_pc,
  output logic              memwb_reg_write,
  output logic [REG_AW-1:0] memwb_rd,
  output logic [DATA_W-1:0] memwb_wdata,
  output logic              memwb_halt,
  output logic              memwb_err,
  output logic [31:0]       dcache_req_count,
  output logic [31:0]       dcache_hit_count
);

  mem_state_e    r_state;
  mem_state_e    w_next_state;
  memwb_bundle_t r_memwb;
  memwb_bundle_t w_next_bundle;
  logic          r_halted;

  logic w_active;
  logic w_memop;
  logic w_plain;
  logic w_capture;
  logic w_err;
  logic w_use_rdata;
  logic w_expired;

  // rst gates the request path so nothing is issued while reset is held.
  assign w_active = rst & ~r_halted;
  assign w_memop  = w_active & exmem_valid & (exmem_mem_read | exmem_mem_write) & ~exmem_halt;
  assign w_plain  = w_active & exmem_valid & ~w_memop;

  assign dmem_addr  = exmem_addr;
  assign dmem_wdata = exmem_wdata;
  assign dmem_wr    = exmem_mem_write & (w_memop | (r_state == WAIT));

  always_comb begin
    w_next_state = r_state;
    dmem_req     = 1'b0;
    mem_busy     = 1'b0;
    w_capture    = 1'b0;
    w_err        = 1'b0;
    w_use_rdata  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop) begin
          dmem_req = 1'b1;
          if (dmem_done) begin
            w_capture   = 1'b1;
            w_err       = dmem_err;
            w_use_rdata = exmem_mem_read;
          end else begin
            mem_busy     = 1'b1;
            w_next_state = WAIT;
          end
        end else if (w_plain) begin
          w_capture = 1'b1;
        end
      end
      WAIT: begin
        // A real completion takes precedence over a coincident timeout.
        if (dmem_done) begin
          w_capture    = 1'b1;
          w_err        = dmem_err;
          w_use_rdata  = exmem_mem_read;
          w_next_state = IDLE;
        end else if (w_expired) begin
          w_capture    = 1'b1;
          w_err        = 1'b1;
          w_use_rdata  = exmem_mem_read;
          w_next_state = IDLE;
        end else begin
          mem_busy = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_next_bundle = '0;
    if (w_capture) begin
      w_next_bundle.valid     = 1'b1;
      w_next_bundle.pc        = exmem_pc;
      w_next_bundle.reg_write = exmem_reg_write & ~w_err;
      w_next_bundle.rd        = exmem_rd;
      w_next_bundle.wdata     = w_use_rdata ? dmem_rdata : exmem_alu_out;
      w_next_bundle.halt      = exmem_halt;
      w_next_bundle.err       = w_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_memwb  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_memwb  <= w_next_bundle;
      r_halted <= r_halted | (w_capture & exmem_halt);
    end
  end

  mem_wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst),
    .i_clear   (w_next_state != WAIT),
    .i_enable  (r_state == WAIT),
    .o_expired (w_expired)
  );

  assign memwb_valid     = r_memwb.valid;
  assign memwb_pc        = r_memwb.pc;
  assign memwb_reg_write = r_memwb.reg_write;
  assign memwb_rd        = r_memwb.rd;
  assign memwb_wdata     = r_memwb.wdata;
  assign memwb_halt      = r_memwb.halt;
  assign memwb_err       = r_memwb.err;

`ifdef MEM_WB_STAGE_PERF_EN
  logic [31:0] r_req_count;
  logic [31:0] r_hit_count;
  logic        w_done_taken;

  // Only completions that belong to an issued access count as hits.
  assign w_done_taken = dmem_done & (w_memop | (r_state == WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_count <= '0;
      r_hit_count <= '0;
    end else if (!r_halted) begin
      if (dmem_req) r_req_count <= r_req_count + 32'd1;
      if (w_done_taken && dmem_hit) r_hit_count <= r_hit_count + 32'd1;
    end
  end

  assign dcache_req_count = r_req_count;
  assign dcache_hit_count = r_hit_count;
`else
  logic w_unused_hit;
  assign w_unused_hit     = dmem_hit;
  assign dcache_req_count = '0;
  assign dcache_hit_count = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push expected writeback
// bundles, an independent monitor pops and compares whenever memwb_valid is seen.
module tb_mem_wb_stage;

  localparam int TIMEOUT = 255;
`ifdef MEM_WB_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        exmem_valid;
  logic [15:0] exmem_pc;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic [15:0] exmem_addr;
  logic [15:0] exmem_wdata;
  logic [15:0] exmem_alu_out;
  logic        exmem_reg_write;
  logic [2:0]  exmem_rd;
  logic        exmem_halt;
  logic        dmem_req;
  logic        dmem_wr;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_done;
  logic        dmem_hit;
  logic        dmem_err;
  logic        mem_busy;
  logic        memwb_valid;
  logic [15:0] memwb_pc;
  logic        memwb_reg_write;
  logic [2:0]  memwb_rd;
  logic [15:0] memwb_wdata;
  logic        memwb_halt;
  logic        memwb_err;
  logic [31:0] dcache_req_count;
  logic [31:0] dcache_hit_count;

  typedef struct {
    logic [15:0] pc;
    logic        regw;
    logic [2:0]  rd;
    logic [15:0] wdata;
    logic        halt;
    logic        err;
  } exp_t;

  exp_t sbQueue[$];
  int   compared   = 0;
  int   mismatched = 0;

  mem_wb_stage #(
    .DATA_W  (16),
    .REG_AW  (3),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .exmem_valid      (exmem_valid),
    .exmem_pc         (exmem_pc),
    .exmem_mem_read   (exmem_mem_read),
    .exmem_mem_write  (exmem_mem_write),
    .exmem_addr       (exmem_addr),
    .exmem_wdata      (exmem_wdata),
    .exmem_alu_out    (exmem_alu_out),
    .exmem_reg_write  (exmem_reg_write),
    .exmem_rd         (exmem_rd),
    .exmem_halt       (exmem_halt),
    .dmem_req         (dmem_req),
    .dmem_wr          (dmem_wr),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_done        (dmem_done),
    .dmem_hit         (dmem_hit),
    .dmem_err         (dmem_err),
    .mem_busy         (mem_busy),
    .memwb_valid      (memwb_valid),
    .memwb_pc         (memwb_pc),
    .memwb_reg_write  (memwb_reg_write),
    .memwb_rd         (memwb_rd),
    .memwb_wdata      (memwb_wdata),
    .memwb_halt       (memwb_halt),
    .memwb_err        (memwb_err),
    .dcache_req_count (dcache_req_count),
    .dcache_hit_count (dcache_hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] pc, input logic mr, input logic mw,
                               input logic [15:0] addr, input logic [15:0] wd, input logic [15:0] alu,
                               input logic rw, input logic [2:0] rd, input logic h);
    exmem_valid     = v;
    exmem_pc        = pc;
    exmem_mem_read  = mr;
    exmem_mem_write = mw;
    exmem_addr      = addr;
    exmem_wdata     = wd;
    exmem_alu_out   = alu;
    exmem_reg_write = rw;
    exmem_rd        = rd;
    exmem_halt      = h;
  endtask

  task automatic clearStimulus();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic pushExpected(input logic [15:0] pc, input logic regw, input logic [2:0] rd,
                              input logic [15:0] wdata, input logic halt, input logic err);
    exp_t e;
    e.pc = pc; e.regw = regw; e.rd = rd; e.wdata = wdata; e.halt = halt; e.err = err;
    sbQueue.push_back(e);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid writeback must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && memwb_valid) begin
      if (sbQueue.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid: got valid pc=0x%0h, required no writeback", memwb_pc);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput("wb_pc",        32'(memwb_pc),        32'(e.pc));
        checkOutput("wb_reg_write", 32'(memwb_reg_write), 32'(e.regw));
        checkOutput("wb_rd",        32'(memwb_rd),        32'(e.rd));
        checkOutput("wb_wdata",     32'(memwb_wdata),     32'(e.wdata));
        checkOutput("wb_halt",      32'(memwb_halt),      32'(e.halt));
        checkOutput("wb_err",       32'(memwb_err),       32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  busyCnt;
    int  reqCnt;
    bit  gone;

    rst = 1'b0;
    dmem_rdata = 16'h0; dmem_done = 1'b0; dmem_hit = 1'b0; dmem_err = 1'b0;
    // A pending load during reset must not raise a request.
    applyStimulus(1'b1, 16'h0008, 1'b1, 1'b1, 16'h0044, 16'h0011, 16'h0044, 1'b1, 3'd1, 1'b0);
    #12;
    checkOutput("rst_req",       32'(dmem_req),    0);
    checkOutput("rst_wr",        32'(dmem_wr),     0);
    checkOutput("rst_busy",      32'(mem_busy),    0);
    checkOutput("rst_valid",     32'(memwb_valid), 0);
    checkOutput("rst_req_count", dcache_req_count, 0);
    checkOutput("rst_hit_count", dcache_hit_count, 0);
    clearStimulus();
    @(negedge clk);
    rst = 1'b1;
    stepCycle();

    // ALU instruction
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234, 1'b1, 3'd3, 1'b0);
    pushExpected(16'h0010, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("alu_busy", 32'(mem_busy), 0);
    checkOutput("alu_req",  32'(dmem_req), 0);
    stepCycle();
    clearStimulus();

    // Zero-wait load hit
    applyStimulus(1'b1, 16'h0014, 1'b1, 1'b0, 16'h0040, 16'h0, 16'h0040, 1'b1, 3'd5, 1'b0);
    dmem_done = 1'b1; dmem_hit = 1'b1; dmem_rdata = 16'hBEEF;
    pushExpected(16'h0014, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("load_req",  32'(dmem_req),  1);
    checkOutput("load_addr", 32'(dmem_addr), 32'h0040);
    checkOutput("load_wr",   32'(dmem_wr),   0);
    checkOutput("load_busy", 32'(mem_busy),  0);
    stepCycle();
    clearStimulus();
    dmem_done = 1'b0; dmem_hit = 1'b0; dmem_rdata = 16'h0;
    @(negedge clk);
    checkOutput("load_req_pulse", 32'(dmem_req), 0);
    stepCycle();

    // Store with done four cycles after the request
    applyStimulus(1'b1, 16'h0018, 1'b0, 1'b1, 16'h0080, 16'h00AA, 16'h0080, 1'b0, 3'd1, 1'b0);
    pushExpected(16'h0018, 1'b0, 3'd1, 16'h0080, 1'b0, 1'b0);
    busyCnt = 0; reqCnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) dmem_done = 1'b1;
      @(negedge clk);
      busyCnt += int'(mem_busy);
      reqCnt  += int'(dmem_req);
      checkOutput("store_wr", 32'(dmem_wr), 1);
      if (i > 0) begin
        checkOutput("store_wdata",  32'(dmem_wdata),  32'h00AA);
        checkOutput("store_bubble", 32'(memwb_valid), 0);
      end
      stepCycle();
    end
    dmem_done = 1'b0;
    clearStimulus();
    checkOutput("store_busy_cycles", 32'(busyCnt), 4);
    checkOutput("store_req_pulses",  32'(reqCnt),  1);

    // Load that never completes: timeout error
    applyStimulus(1'b1, 16'h001C, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h0100, 1'b1, 3'd2, 1'b0);
    pushExpected(16'h001C, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b1);
    busyCnt = 0; gone = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mem_busy) busyCnt++;
      else gone = 1'b1;
      stepCycle();
      if (gone) break;
    end
    clearStimulus();
    checkOutput("timeout_seen",        32'(gone),    1);
    checkOutput("timeout_busy_cycles", 32'(busyCnt), TIMEOUT + 1);

    // Instruction after the timeout proceeds normally
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, 16'h5555, 1'b1, 3'd4, 1'b0);
    pushExpected(16'h0020, 1'b1, 3'd4, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post_timeout_busy", 32'(mem_busy), 0);
    stepCycle();
    clearStimulus();

    // Load completing with a fault
    applyStimulus(1'b1, 16'h0024, 1'b1, 1'b0, 16'h0300, 16'h0, 16'h0300, 1'b1, 3'd6, 1'b0);
    dmem_done = 1'b1; dmem_err = 1'b1; dmem_rdata = 16'h0BAD;
    pushExpected(16'h0024, 1'b0, 3'd6, 16'h0BAD, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("err_busy", 32'(mem_busy), 0);
    stepCycle();
    clearStimulus();
    dmem_done = 1'b0; dmem_err = 1'b0; dmem_rdata = 16'h0;

    // Stray done with no request is ignored
    dmem_done = 1'b1; dmem_hit = 1'b1;
    @(negedge clk);
    checkOutput("stray_busy", 32'(mem_busy), 0);
    checkOutput("stray_req",  32'(dmem_req), 0);
    stepCycle();
    dmem_done = 1'b0; dmem_hit = 1'b0;
    @(negedge clk);
    checkOutput("stray_valid", 32'(memwb_valid), 0);
    checkOutput("perf_req_mid", dcache_req_count, PERF ? 32'd4 : 32'd0);
    checkOutput("perf_hit_mid", dcache_hit_count, PERF ? 32'd1 : 32'd0);
    stepCycle();

    // Halt carrying a load flag, then a load that must be ignored
    applyStimulus(1'b1, 16'h0028, 1'b1, 1'b0, 16'h0400, 16'h0, 16'h0028, 1'b0, 3'd0, 1'b1);
    dmem_rdata = 16'h7777;
    pushExpected(16'h0028, 1'b0, 3'd0, 16'h0028, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("halt_req", 32'(dmem_req), 0);
    stepCycle();
    dmem_rdata = 16'h0;
    applyStimulus(1'b1, 16'h002C, 1'b1, 1'b0, 16'h0404, 16'h0, 16'h0404, 1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("halted_req",  32'(dmem_req),   0);
      checkOutput("halted_busy", 32'(mem_busy),   0);
      checkOutput("halted_halt", 32'(memwb_halt), (i == 0) ? 32'd1 : 32'd0);
      if (i > 0) checkOutput("halted_valid", 32'(memwb_valid), 0);
      stepCycle();
    end

    // Reset to leave the halted state
    rst = 1'b0;
    sbQueue.delete();
    clearStimulus();
    stepCycle();
    rst = 1'b1;
    stepCycle();

    // Reset asserted in the middle of a WAIT
    applyStimulus(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0200, 16'h0, 16'h0200, 1'b1, 3'd7, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("prereset_busy", 32'(mem_busy), 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_req",   32'(dmem_req),    0);
    checkOutput("midrst_busy",  32'(mem_busy),    0);
    checkOutput("midrst_wr",    32'(dmem_wr),     0);
    checkOutput("midrst_valid", 32'(memwb_valid), 0);
    checkOutput("midrst_req_count", dcache_req_count, 0);
    clearStimulus();
    #1;
    rst = 1'b1;
    stepCycle();

    // Fresh load after reset release
    applyStimulus(1'b1, 16'h0034, 1'b1, 1'b0, 16'h0210, 16'h0, 16'h0210, 1'b1, 3'd7, 1'b0);
    dmem_done = 1'b1; dmem_hit = 1'b1; dmem_rdata = 16'hCAFE;
    pushExpected(16'h0034, 1'b1, 3'd7, 16'hCAFE, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("postrst_req",  32'(dmem_req),  1);
    checkOutput("postrst_busy", 32'(mem_busy),  0);
    stepCycle();
    clearStimulus();
    dmem_done = 1'b0; dmem_hit = 1'b0; dmem_rdata = 16'h0;

    stepCycle();
    stepCycle();
    checkOutput("sb_empty",       32'(sbQueue.size()), 0);
    checkOutput("perf_req_final", dcache_req_count, PERF ? 32'd1 : 32'd0);
    checkOutput("perf_hit_final", dcache_hit_count, PERF ? 32'd1 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
